uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
- Transmit-side byte buffer that sits directly upstream of the UART transmitter (the `tx_start` / `tx_data` / `tx_done` interface of the UART top level).
- Accepts bytes from a host/bus writer at any rate up to one per clock and stores them in a synchronous FIFO.
- Launches one UART frame per byte, waiting for each frame's completion pulse before launching the next.
- Decouples bursty producers from the slow baud-rate serializer.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of two, at least 2.
- AW, $clog2(DEPTH), pointer width. Derived; not overridden.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write strobe; byte accepted when `wr_en && !full`.
- wr_data  input  8  byte to enqueue.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  AW+1  current FIFO occupancy, 0..DEPTH.
- overflow  output  1  sticky flag: a write was attempted while full.
- busy  output  1  FSM not in IDLE (a frame is being launched or is in flight).
- tx_start  output  1  one-cycle launch pulse to the transmitter.
- tx_data  output  8  byte to transmit; held stable from `tx_start` until `tx_done`.
- tx_done  input  1  one-cycle completion pulse from the transmitter.

Behaviour:
Reset (`rst` = 1, synchronous; takes priority over every other input in that cycle):
- Pointers = 0, `count` = 0, `empty` = 1, `full` = 0.
- `overflow` = 0, `busy` = 0, `tx_start` = 0, `tx_data` = 8'h00.
- FSM = IDLE.
- FIFO memory contents are not reset.
- Reset mid-frame abandons the frame and discards all queued bytes. A `tx_done` arriving after reset while in IDLE is ignored.

FIFO:
- Write when `wr_en && !full`: `mem[wr_ptr] <= wr_data`, `wr_ptr` increments modulo DEPTH.
- Pop is internal only: occurs on the IDLE->LOAD transition; `rd_ptr` increments modulo DEPTH.
- `count` is updated registered: +1 on write only, -1 on pop only, unchanged when both occur in the same cycle.
- Write when full: byte dropped, `count` unchanged, `overflow` <= 1 (cleared only by reset). This holds even if a pop occurs in the same cycle.
- Pop never occurs when empty.
- `full` = (`count` == DEPTH); `empty` = (`count` == 0). Both are combinational from the registered `count`.

FSM states: IDLE, LOAD, START, WAIT_DONE.
- IDLE: if `!empty`, then `tx_data` <= `mem[rd_ptr]`, pop, go to LOAD. Otherwise stay.
- LOAD: one cycle for data settle; go to START.
- START: `tx_start` = 1 for exactly this cycle (registered output); go to WAIT_DONE.
- WAIT_DONE: hold `tx_data`. On `tx_done` = 1, go to IDLE. `tx_done` pulses in any other state are ignored.
- `busy` = (state != IDLE).

Latency:
- Write accepted at edge N into an empty FIFO with FSM in IDLE: pop at edge N+1, `tx_start` high during the cycle after edge N+3. That is three cycles from write to launch.
- `tx_done` at edge M with FIFO non-empty: next `tx_start` high during the cycle after edge M+3.

Ordering: bytes are transmitted strictly in write order. No byte is transmitted twice or skipped, except bytes dropped on overflow.

Decomposition:
- Shared package `uart_pkg`:
  - state enum `tx_fifo_state_t` {IDLE, LOAD, START, WAIT_DONE};
  - constant `UART_DATA_W` = 8;
  - default `TX_FIFO_DEPTH` = 16.
- One sub-module, `sync_fifo`:
  - parameters: WIDTH, DEPTH;
  - ports: `clk`, `rst`, `wr_en`, `wr_data`, `rd_en`, `rd_data` (combinational at `rd_ptr`), `full`, `empty`, `count`, `overflow`.
- `uart_tx_fifo` contains the FSM plus one `sync_fifo` instance.

Test Plan:
1. Reset, then single write 8'hA5 at cycle 10 -> `tx_start` pulses at cycle 13, `tx_data` = 8'hA5 until a `tx_done` pulse injected at cycle 40; `busy` = 0 at cycle 41; `empty` = 1.
2. Burst-write 16 bytes 8'h00..8'h0F back-to-back, with a bench model returning `tx_done` 20 cycles after each `tx_start` -> exactly 16 `tx_start` pulses, `tx_data` sequence 00..0F; `full` never asserted (one byte is popped during the burst); `overflow` = 0.
3. Hold `tx_done` = 0, write 17 bytes -> after 17 writes `count` = 16, `full` = 1 (1 in flight + 16 queued); 18th write 8'hFF dropped, `overflow` = 1; after releasing `tx_done`, 8'hFF never appears on `tx_data`.
4. Write in the same cycle the FSM pops (FIFO count 1, FSM IDLE) -> `count` stays 1 across that edge; both bytes later transmitted in order.
5. Assert `rst` while in WAIT_DONE with 5 bytes queued -> next cycle `busy` = 0, `count` = 0, `tx_start` = 0; a stray `tx_done` 3 cycles later produces no `tx_start`.
6. `tx_done` pulse while IDLE and empty -> no state change, no `tx_start`, `count` = 0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and the transmit-FIFO launcher state type
package uart_pkg;
   localparam int UART_DATA_W   = 8;
   localparam int TX_FIFO_DEPTH = 16;
   typedef enum logic [1:0] {IDLE, LOAD, START, WAIT_DONE} tx_fifo_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy and sticky overflow
// Ports: clk/rst (sync, active-high); wr_en/wr_data push; rd_en pops, rd_data
// shows the head combinationally; full/empty/count report occupancy;
// overflow latches any write attempted while full until reset.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count,
   output logic             overflow
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
   logic [AW:0]      r_count;
   logic             r_overflow;
   logic             w_wr, w_rd;
   assign full     = r_count == (AW+1)'(DEPTH);
   assign empty    = r_count == '0;
   assign count    = r_count;
   assign overflow = r_overflow;
   assign rd_data  = r_mem[r_rd_ptr];
   assign w_wr     = wr_en && !full;
   assign w_rd     = rd_en && !empty;
   always_ff @(posedge clk)
      if (w_wr) r_mem[r_wr_ptr] <= wr_data;
   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_wr && !w_rd) r_count <= r_count + 1'b1;
         else if (!w_wr && w_rd) r_count <= r_count - 1'b1;
         if (wr_en && full) r_overflow <= 1'b1;
      end
   end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that launches one UART frame per queued byte
// Ports: clk/rst (sync, active-high); wr_en/wr_data enqueue; full/empty/count/
// overflow report the queue; busy while a frame is launched or in flight;
// tx_start/tx_data drive the transmitter, tx_done is its completion pulse.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = TX_FIFO_DEPTH,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [UART_DATA_W-1:0] wr_data,
   output logic                   full,
   output logic                   empty,
   output logic [AW:0]            count,
   output logic                   overflow,
   output logic                   busy,
   output logic                   tx_start,
   output logic [UART_DATA_W-1:0] tx_data,
   input  logic                   tx_done
);
   tx_fifo_state_t         r_state, w_next;
   logic                   r_tx_start;
   logic [UART_DATA_W-1:0] r_tx_data, w_rd_data;
   logic                   w_pop;
   sync_fifo #(.WIDTH(UART_DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .rd_en    (w_pop),
      .rd_data  (w_rd_data),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (overflow)
   );
   always_comb begin
      w_pop  = (r_state == IDLE) && !empty;
      w_next = (r_state == IDLE)  ? (empty ? IDLE : LOAD) :
               (r_state == LOAD)  ? START :
               (r_state == START) ? WAIT_DONE :
               (tx_done ? IDLE : WAIT_DONE);
   end
   // tx_start is registered off START, so it is high the cycle after START
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_tx_start <= 1'b0;
         r_tx_data  <= '0;
      end else begin
         r_state    <= w_next;
         r_tx_start <= r_state == START;
         if (w_pop) r_tx_data <= w_rd_data;
      end
   end
   assign busy     = r_state != IDLE;
   assign tx_start = r_tx_start;
   assign tx_data  = r_tx_data;
endmodule
